// File: rtl/vga_stream_if.sv
// Pixel request/return and video output bundle for vga_stream_gen.
// master = timing generator, slave = pixel source plus video consumer.
interface vga_stream_if;
    // pix_req/pix_x/pix_y are registered on a pixel tick; the slave must hold
    // pix_rgb valid for that request at the following tick. There is no ready:
    // a request can never be refused or stalled.
    logic        pix_req;
    logic [10:0] pix_x;
    logic [9:0]  pix_y;
    logic [23:0] pix_rgb;
    logic        vga_ce;
    logic [7:0]  vga_r;
    logic [7:0]  vga_g;
    logic [7:0]  vga_b;
    logic        vga_hs;
    logic        vga_vs;
    logic        vga_de;
    logic        frame_start;

    modport master (
        output pix_req, pix_x, pix_y, vga_ce, vga_r, vga_g, vga_b,
               vga_hs, vga_vs, vga_de, frame_start,
        input  pix_rgb
    );

    modport slave (
        input  pix_req, pix_x, pix_y, vga_ce, vga_r, vga_g, vga_b,
               vga_hs, vga_vs, vga_de, frame_start,
        output pix_rgb
    );
endinterface

// File: rtl/vga_stream_gen.sv
// VGA timing generator with a two-stage request/output pixel pipeline.
// Optional colour-bar source compiled in with VGA_STREAM_TEST_PATTERN_EN.
module vga_stream_gen #(
    parameter int CE_DIV   = 2,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0
) (
    input  logic              clk_vga,
    input  logic              resetn,
    input  logic              run,
    input  logic              pattern_sel,
    vga_stream_if.master      vif,
    output logic              dbg_active
);
    localparam int CW      = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] CE_LAST = CW'(CE_DIV - 1);
    localparam logic [10:0]   H_LAST  = 11'(H_TOTAL - 1);
    localparam logic [9:0]    V_LAST  = 10'(V_TOTAL - 1);
    localparam logic [11:0]   H_ACT   = 12'(H_ACTIVE);
    localparam logic [11:0]   HS_BEG  = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0]   HS_END  = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0]   V_ACT   = 11'(V_ACTIVE);
    localparam logic [10:0]   VS_BEG  = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0]   VS_END  = 11'(V_ACTIVE + V_FP + V_SYNC);

    typedef enum logic {ST_STOPPED = 1'b0, ST_ACTIVE = 1'b1} state_t;

    state_t      state_q, state_d;
    logic [CW-1:0] ce_cnt_q, ce_cnt_d;
    logic [10:0] h_q, h_d;
    logic [9:0]  v_q, v_d;
    logic        vga_ce_q, vga_ce_d;
    // stage A: request plus the timing flags of the requested pixel
    logic [10:0] pix_x_q, pix_x_d;
    logic [9:0]  pix_y_q, pix_y_d;
    logic        pix_req_q, pix_req_d;
    logic        a_hs_q, a_hs_d;
    logic        a_vs_q, a_vs_d;
    logic        frame_start_q, frame_start_d;
    // stage B: what the video sink sees
    logic        vga_de_q, vga_de_d;
    logic        vga_hs_q, vga_hs_d;
    logic        vga_vs_q, vga_vs_d;
    logic [23:0] rgb_q, rgb_d;

    logic        tick;
    logic        running;
    logic        in_act;
    logic        in_hs;
    logic        in_vs;
    logic [23:0] src_rgb;

`ifdef VGA_STREAM_TEST_PATTERN_EN
    logic [2:0]  bar_idx;
    logic [23:0] bar_rgb;

    always_comb begin
        bar_idx = 3'((32'(pix_x_q) << 3) / 32'(H_ACTIVE));
        case (bar_idx)
            3'd0:    bar_rgb = 24'hFFFFFF;
            3'd1:    bar_rgb = 24'hFFFF00;
            3'd2:    bar_rgb = 24'h00FFFF;
            3'd3:    bar_rgb = 24'h00FF00;
            3'd4:    bar_rgb = 24'hFF00FF;
            3'd5:    bar_rgb = 24'hFF0000;
            3'd6:    bar_rgb = 24'h0000FF;
            default: bar_rgb = 24'h000000;
        endcase
    end

    assign src_rgb = pattern_sel ? bar_rgb : vif.pix_rgb;
`else
    logic unused_pattern_sel;
    assign unused_pattern_sel = pattern_sel;
    assign src_rgb            = vif.pix_rgb;
`endif

    always_comb begin
        state_d       = state_q;
        h_d           = h_q;
        v_d           = v_q;
        pix_x_d       = pix_x_q;
        pix_y_d       = pix_y_q;
        pix_req_d     = pix_req_q;
        a_hs_d        = a_hs_q;
        a_vs_d        = a_vs_q;
        vga_de_d      = vga_de_q;
        vga_hs_d      = vga_hs_q;
        vga_vs_d      = vga_vs_q;
        rgb_d         = rgb_q;
        frame_start_d = 1'b0;

        tick     = (ce_cnt_q == CE_LAST);
        ce_cnt_d = tick ? '0 : ce_cnt_q + 1'b1;
        vga_ce_d = tick;

        // A stopped generator restarts at the first tick that sees run high.
        running = (state_q == ST_ACTIVE) || run;
        in_act  = ({1'b0, h_q} < H_ACT) && ({1'b0, v_q} < V_ACT);
        in_hs   = ({1'b0, h_q} >= HS_BEG) && ({1'b0, h_q} < HS_END);
        in_vs   = ({1'b0, v_q} >= VS_BEG) && ({1'b0, v_q} < VS_END);

        if (tick) begin
            pix_x_d       = h_q;
            pix_y_d       = v_q;
            pix_req_d     = in_act && running;
            a_hs_d        = (in_hs && running) ? HS_POL : ~HS_POL;
            a_vs_d        = (in_vs && running) ? VS_POL : ~VS_POL;
            frame_start_d = (h_q == '0) && (v_q == '0) && running;

            vga_de_d = pix_req_q;
            vga_hs_d = a_hs_q;
            vga_vs_d = a_vs_q;
            rgb_d    = pix_req_q ? src_rgb : 24'h0;

            if (running) begin
                state_d = ST_ACTIVE;
                if (h_q == H_LAST) begin
                    h_d = '0;
                    if (v_q == V_LAST) begin
                        v_d     = '0;
                        state_d = run ? ST_ACTIVE : ST_STOPPED;
                    end else begin
                        v_d = v_q + 1'b1;
                    end
                end else begin
                    h_d = h_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_vga) begin
        if (!resetn) begin
            state_q       <= ST_STOPPED;
            ce_cnt_q      <= '0;
            h_q           <= '0;
            v_q           <= '0;
            vga_ce_q      <= 1'b0;
            pix_x_q       <= '0;
            pix_y_q       <= '0;
            pix_req_q     <= 1'b0;
            a_hs_q        <= ~HS_POL;
            a_vs_q        <= ~VS_POL;
            frame_start_q <= 1'b0;
            vga_de_q      <= 1'b0;
            vga_hs_q      <= ~HS_POL;
            vga_vs_q      <= ~VS_POL;
            rgb_q         <= '0;
        end else begin
            state_q       <= state_d;
            ce_cnt_q      <= ce_cnt_d;
            h_q           <= h_d;
            v_q           <= v_d;
            vga_ce_q      <= vga_ce_d;
            pix_x_q       <= pix_x_d;
            pix_y_q       <= pix_y_d;
            pix_req_q     <= pix_req_d;
            a_hs_q        <= a_hs_d;
            a_vs_q        <= a_vs_d;
            frame_start_q <= frame_start_d;
            vga_de_q      <= vga_de_d;
            vga_hs_q      <= vga_hs_d;
            vga_vs_q      <= vga_vs_d;
            rgb_q         <= rgb_d;
        end
    end

    assign vif.vga_ce      = vga_ce_q;
    assign vif.pix_req     = pix_req_q;
    assign vif.pix_x       = pix_x_q;
    assign vif.pix_y       = pix_y_q;
    assign vif.frame_start = frame_start_q;
    assign vif.vga_de      = vga_de_q;
    assign vif.vga_hs      = vga_hs_q;
    assign vif.vga_vs      = vga_vs_q;
    assign vif.vga_r       = rgb_q[23:16];
    assign vif.vga_g       = rgb_q[15:8];
    assign vif.vga_b       = rgb_q[7:0];
    assign dbg_active      = (state_q == ST_ACTIVE);
endmodule

// File: tb/tb_vga_stream_gen.sv
// Directed bench for vga_stream_gen on a shrunken 16x8 raster, CE_DIV=2.
// Colour-bar expectations follow VGA_STREAM_TEST_PATTERN_EN when defined.
module tb_vga_stream_gen;
    localparam int HA = 8;
    localparam int HF = 2;
    localparam int HS = 3;
    localparam int HB = 3;
    localparam int VA = 4;
    localparam int VF = 1;
    localparam int VS = 2;
    localparam int VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;

    logic clk_vga = 1'b0;
    logic resetn;
    logic run;
    logic pattern_sel;
    logic dbg_active;

    int n_checks = 0;
    int n_errors = 0;

    // Expected stage-B output of each request: {de, hs, vs, rgb}.
    logic [26:0] exp_q[$];

    vga_stream_if vif ();

    // Source model: returns {x, y, 5A} for whatever is requested.
    assign vif.pix_rgb = {vif.pix_x[7:0], vif.pix_y[7:0], 8'h5A};

    vga_stream_gen #(
        .CE_DIV(2),
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HS_POL(1'b0), .VS_POL(1'b0)
    ) dut (
        .clk_vga(clk_vga),
        .resetn(resetn),
        .run(run),
        .pattern_sel(pattern_sel),
        .vif(vif),
        .dbg_active(dbg_active)
    );

    always #5 clk_vga = ~clk_vga;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, observed running expected finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] bar_rgb(input int x);
        case (x)
            0:       return 24'hFFFFFF;
            1:       return 24'hFFFF00;
            2:       return 24'h00FFFF;
            3:       return 24'h00FF00;
            4:       return 24'hFF00FF;
            5:       return 24'hFF0000;
            6:       return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    function automatic logic [26:0] exp_b(input int x, input int y, input bit on);
        logic        de;
        logic        hs;
        logic        vs;
        logic [23:0] rgb;
        de  = on && (x < HA) && (y < VA);
        hs  = (on && x >= HA + HF && x < HA + HF + HS) ? 1'b0 : 1'b1;
        vs  = (on && y >= VA + VF && y < VA + VF + VS) ? 1'b0 : 1'b1;
        rgb = {x[7:0], y[7:0], 8'h5A};
`ifdef VGA_STREAM_TEST_PATTERN_EN
        if (pattern_sel) rgb = bar_rgb(x);
`endif
        if (!de) rgb = 24'h0;
        return {de, hs, vs, rgb};
    endfunction

    task automatic check_reset_vals();
        chk("rst_ce", vif.vga_ce, 0);
        chk("rst_req", vif.pix_req, 0);
        chk("rst_de", vif.vga_de, 0);
        chk("rst_fs", vif.frame_start, 0);
        chk("rst_x", vif.pix_x, 0);
        chk("rst_y", vif.pix_y, 0);
        chk("rst_rgb", {vif.vga_r, vif.vga_g, vif.vga_b}, 0);
        chk("rst_hs", vif.vga_hs, 1);
        chk("rst_vs", vif.vga_vs, 1);
        chk("rst_active", dbg_active, 0);
    endtask

    // Advance to just after the next tick edge and check both stages.
    task automatic do_tick(input int x, input int y, input bit on);
        logic [26:0] e;
        @(negedge clk_vga);
        chk("ce_between", vif.vga_ce, 0);
        chk("fs_between", vif.frame_start, 0);
        @(negedge clk_vga);
        chk("ce_tick", vif.vga_ce, 1);
        chk("req", vif.pix_req, (on && x < HA && y < VA) ? 1 : 0);
        chk("pix_x", vif.pix_x, on ? x : 0);
        chk("pix_y", vif.pix_y, on ? y : 0);
        chk("frame_start", vif.frame_start, (on && x == 0 && y == 0) ? 1 : 0);
        chk("active", dbg_active, (on && !(x == HT - 1 && y == VT - 1 && !run)) ? 1 : 0);
        if (exp_q.size() == 0) begin
            chk("exp_q_empty", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            chk("de", vif.vga_de, e[26]);
            chk("hs", vif.vga_hs, e[25]);
            chk("vs", vif.vga_vs, e[24]);
            chk("rgb", {vif.vga_r, vif.vga_g, vif.vga_b}, e[23:0]);
        end
        exp_q.push_back(exp_b(x, y, on));
    endtask

    task automatic run_frame(input int drop_line);
        for (int y = 0; y < VT; y++) begin
            for (int x = 0; x < HT; x++) begin
                if (y == drop_line && x == 0) run = 1'b0;
                do_tick(x, y, 1'b1);
            end
        end
    endtask

    task automatic apply_reset(input int cycles);
        resetn = 1'b0;
        repeat (cycles) @(negedge clk_vga);
        check_reset_vals();
        resetn = 1'b1;
        exp_q.delete();
        exp_q.push_back({1'b0, 1'b1, 1'b1, 24'h0});
    endtask

    initial begin
        run         = 1'b1;
        pattern_sel = 1'b0;
        @(negedge clk_vga);
        apply_reset(5);

        // Two back-to-back frames, including the frame wrap.
        run_frame(-1);
        run_frame(-1);

        // Reset in the middle of line 1; the raster restarts at (0,0).
        for (int x = 0; x < HT; x++) do_tick(x, 0, 1'b1);
        for (int x = 0; x < 4; x++) do_tick(x, 1, 1'b1);
        apply_reset(1);
        run_frame(-1);

        // Drop run mid-frame: frame completes, then idle with ce still pulsing.
        run_frame(2);
        for (int i = 0; i < 6; i++) do_tick(0, 0, 1'b0);

        // Restart: frame_start on the next tick, de one tick later.
        run = 1'b1;
        run_frame(-1);

        pattern_sel = 1'b1;
        run_frame(-1);
        do_tick(0, 0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
